// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer redirect, ROM and IF/ID signal bundle
interface fetch_sequencer_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        irq;
  logic        exc;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        kernel;
  logic        epc_we;
  logic [31:0] epc_value;

  modport master (
    input  stall, br_taken, br_target, jump, jump_target, jr, jr_target,
           irq, exc, rom_data,
    output rom_addr, ifid_inst, ifid_pc, ifid_valid, kernel, epc_we, epc_value
  );

  modport slave (
    output stall, br_taken, br_target, jump, jump_target, jr, jr_target,
           irq, exc, rom_data,
    input  rom_addr, ifid_inst, ifid_pc, ifid_valid, kernel, epc_we, epc_value
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner, next-PC arbiter, IF/ID register and EPC writer
module fetch_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);
  logic [31:0] pc;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        epc_we;
  logic [31:0] epc_value;

  logic        exc_take;
  logic        irq_take;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] seq_pc;

  assign bus.rom_addr   = pc;
  assign bus.kernel     = pc[31];
  assign bus.ifid_inst  = ifid_inst;
  assign bus.ifid_pc    = ifid_pc;
  assign bus.ifid_valid = ifid_valid;
  assign bus.epc_we     = epc_we;
  assign bus.epc_value  = epc_value;

  // Increment never touches the kernel bit; the low 31 bits wrap on their own.
  assign seq_pc = {pc[31], pc[30:0] + 31'd4};

  assign exc_take = bus.exc & ifid_valid;
  assign irq_take = bus.irq & ~pc[31] & ~bus.stall & ~bus.br_taken & ~bus.jump
                  & ~bus.jr & ifid_valid;

  always_comb begin
    redirect    = 1'b1;
    redirect_pc = seq_pc;
    if (exc_take)          redirect_pc = EXC_VEC;
    else if (irq_take)     redirect_pc = IRQ_VEC;
    else if (bus.jr)       redirect_pc = bus.jr_target;
    else if (bus.br_taken) redirect_pc = bus.br_target;
    else if (bus.jump)     redirect_pc = {pc[31], bus.jump_target[30:0]};
    else                   redirect    = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_VEC;
      ifid_inst  <= 32'd0;
      ifid_pc    <= RESET_VEC;
      ifid_valid <= 1'b0;
      epc_we     <= 1'b0;
      epc_value  <= 32'd0;
    end else begin
      epc_we <= exc_take | irq_take;
      // Exceptions skip the faulting instruction; interrupts replay the flushed one.
      if (exc_take)      epc_value <= ifid_pc + 32'd4;
      else if (irq_take) epc_value <= ifid_pc;

      if (redirect) begin
        pc         <= redirect_pc;
        ifid_inst  <= 32'd0;
        ifid_pc    <= pc;
        ifid_valid <= 1'b0;
      end else if (!bus.stall) begin
        pc         <= seq_pc;
        ifid_inst  <= bus.rom_data;
        ifid_pc    <= pc;
        ifid_valid <= 1'b1;
      end
    end
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction ROM address. Captures the returned word into the IF/ID register.
- Arbitrates next-PC among reset, exception, interrupt, jr, branch, jump, stall and sequential fetch.
- Maintains the kernel bit PC[31] and emits the EPC write for $k0 ($26).

Parameters:
- RESET_VEC, 32'h8000_0000, reset vector (kernel mode).
- IRQ_VEC, 32'h8000_0004, interrupt vector.
- EXC_VEC, 32'h8000_0008, undefined-instruction exception vector.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  load-use hazard hold; PC and IF/ID keep their values.
- br_taken  in  1  branch resolved taken (from ID).
- br_target  in  32  branch target.
- jump  in  1  j/jal in ID.
- jump_target  in  32  jump target; bit 31 is ignored and the current PC[31] is used.
- jr  in  1  jr/jalr in ID.
- jr_target  in  32  full register target; bit 31 is honoured.
- irq  in  1  level timer interrupt request.
- exc  in  1  undefined instruction detected in ID.
- rom_addr  out  32  current PC, drives the ROM.
- rom_data  in  32  ROM word, combinational from rom_addr.
- ifid_inst  out  32  IF/ID instruction register.
- ifid_pc  out  32  address of ifid_inst.
- ifid_valid  out  1  IF/ID holds a real instruction.
- kernel  out  1  equals PC[31].
- epc_we  out  1  one-cycle write strobe for $26.
- epc_value  out  32  value to write to $26.

Behaviour:
- Reset (asynchronous, while reset=0):
  - PC=RESET_VEC.
  - ifid_inst=0 (nop), ifid_pc=RESET_VEC, ifid_valid=0.
  - epc_we=0, epc_value=0.
  - Reset may assert mid-operation; all state returns to these values immediately.
- Registers: PC, IF/ID, epc_we and epc_value are all registered. rom_addr=PC combinationally; kernel=PC[31].
- Sequential increment: next={PC[31], PC[30:0]+4}. Wrap of PC[30:0] at 0x7FFF_FFFC goes to 0; bit 31 never changes by increment.
- Next-PC priority, highest first:
  - exc: PC<=EXC_VEC; flush IF/ID; epc_value<=ifid_pc+4 (skip the faulting instruction); epc_we<=1. exc is honoured regardless of stall or kernel mode, provided ifid_valid=1.
  - irq_take = irq & ~PC[31] & ~stall & ~br_taken & ~jump & ~jr & ifid_valid. On irq_take: PC<=IRQ_VEC; flush IF/ID; epc_value<=ifid_pc (the flushed instruction is re-executed); epc_we<=1.
    - An irq blocked by any of these terms is deferred, not lost, while irq stays high.
  - jr: PC<=jr_target; flush IF/ID. jr may clear the kernel bit (return via $26).
  - br_taken: PC<=br_target; flush IF/ID.
  - jump: PC<=jump_target with bit 31 replaced by the current PC[31]; flush IF/ID.
  - stall: PC and IF/ID hold.
  - default: PC<=sequential increment; ifid_inst<=rom_data; ifid_pc<=PC; ifid_valid<=1.
- Flush: ifid_inst<=0, ifid_valid<=0, ifid_pc<=PC. This gives a one-bubble penalty on every redirect.
- epc_we is high for exactly one cycle, the cycle after the take; otherwise 0. epc_value holds its last value.
- Kernel mode: irq is ignored while PC[31]=1. The kernel bit is set at the same edge that loads the vector, so a level irq cannot re-enter the handler.
- Simultaneous events:
  - exc+irq: exc wins; irq is re-evaluated after the return.
  - redirect+stall: the redirect wins. ID must not assert a redirect while stalling.
- Latency: redirect request in cycle N → ROM sees the target in N+1 → target instruction is in IF/ID in N+2.

Test Plan:
- Reset release, no redirects → rom_addr 0x80000000, 0x80000004, 0x80000008 on successive cycles; ifid_valid goes high one cycle after release; ifid_pc lags rom_addr by one cycle.
- jr_target=0x0000_00BC in kernel mode → next rom_addr 0x0000_00BC, kernel=0, one nop bubble in IF/ID.
- User mode, ifid_pc=0x0000_0010 valid, irq=1 → next rom_addr 0x8000_0004, kernel=1, epc_we=1 for one cycle with epc_value 0x0000_0010. irq held high in the handler → no re-entry.
- irq asserted together with br_taken (target 0x0000_0070) → branch taken first; irq taken next cycle with epc_value 0x0000_0070 once IF/ID is valid.
- exc with ifid_pc=0x0000_0020 → rom_addr 0x8000_0008, epc_value 0x0000_0024. exc with irq simultaneously → EXC_VEC.
- stall held 3 cycles with irq=1 → PC and IF/ID frozen, no epc_we. Stall release → IRQ_VEC. Reset pulse mid-handler → immediately PC=0x80000000, epc_we=0.
